// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential double-dabble binary-to-BCD converter.
// Ports: clk, resetB (async low), start/bin in; busy, done, bcd, ovf, blank out.
// Optional leading-zero blanking: define BCD_CONVERT_SEQ_LZ_BLANK_EN.
module bcd_convert_seq #(
    parameter int BIN_W   = 14,
    parameter int DIGITS  = 4,
    parameter int MAX_VAL = 9999
) (
    input  logic                clk,
    input  logic                resetB,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf,
    output logic [DIGITS-1:0]   blank
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);

    localparam logic [BIN_W:0]  MAXV     = (BIN_W + 1)'(MAX_VAL);
    localparam logic [SW-1:0]   NINES    = {DIGITS{4'h9}};
    localparam logic [CW-1:0]   CNT_INIT = CW'(BIN_W);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [BIN_W-1:0]    sreg;
    logic [SW-1:0]       scr;
    logic [CW-1:0]       cnt;
    logic                over;
    logic [SW-1:0]       adj;
    logic [SW+BIN_W-1:0] shifted;

    // add-3 correction on every digit that would overflow past 9 when doubled
    always_comb begin
        adj = scr;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
        end
    end

    // the top carry falls off here; only matters when saturating anyway
    assign shifted = {adj, sreg} << 1;

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state <= IDLE;
            sreg  <= '0;
            scr   <= '0;
            cnt   <= '0;
            over  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= bin;
                        scr   <= '0;
                        cnt   <= CNT_INIT;
                        over  <= ({1'b0, bin} > MAXV);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {scr, sreg} <= shifted;
                    cnt         <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE)
                        state <= DONE;
                end
                DONE: begin
                    bcd   <= over ? NINES : scr;
                    ovf   <= over;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCD_CONVERT_SEQ_LZ_BLANK_EN
    logic [DIGITS-1:0] blank_nx;
    logic              zrun;

    // walk down from the top digit; a digit blanks only while all above are 0
    always_comb begin
        blank_nx = '0;
        zrun     = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zrun        = zrun & (scr[4*k +: 4] == 4'd0);
            blank_nx[k] = zrun;
        end
    end

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB)
            blank <= '0;
        else if (state == DONE)
            blank <= over ? '0 : blank_nx;
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// tb_bcd_convert_seq: scoreboard bench for bcd_convert_seq.
// Expected results queued at stimulus, popped when done pulses.
module tb_bcd_convert_seq;

    logic        clk = 1'b0;
    logic        resetB = 1'b0;
    logic        start = 1'b0;
    logic [13:0] bin = '0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    exp_t q[$];

    bcd_convert_seq dut (
        .clk    (clk),
        .resetB (resetB),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd),
        .ovf    (ovf),
        .blank  (blank)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int v);
        exp_t e;
        e.blank = '0;
        if (v > 9999) begin
            e.bcd = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10),
                     4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
`ifdef BCD_CONVERT_SEQ_LZ_BLANK_EN
            e.blank[3] = (v < 1000);
            e.blank[2] = (v < 100);
            e.blank[1] = (v < 10);
`endif
        end
        return e;
    endfunction

    function automatic exp_t pop_exp();
        if (q.size() == 0)
            return '1;
        return q.pop_front();
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic launch(input int v);
        bin   = 14'(v);
        start = 1'b1;
        q.push_back(model(v));
    endtask

    // start is dropped after the first edge; lat = edges from start to done
    task automatic wait_done(input int budget, output int lat,
                             output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= budget; n++) begin
            tick();
            start = 1'b0;
            if (busy)
                bcnt++;
            if (done) begin
                lat = n - 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetB = 1'b0;
        start  = 1'b0;
        tick();
        tick();
        checks++;
        if (bcd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_bcd got=%h want=0000", bcd);
        end
        checks++;
        if ({busy, done, ovf, blank} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000000",
                     {busy, done, ovf, blank});
        end
        resetB = 1'b1;
        tick();
    endtask

    task automatic test_zero();
        int lat;
        int bcnt;
        exp_t e;
        launch(0);
        wait_done(30, lat, bcnt);
        checks++;
        if (lat !== 15) begin
            failures++;
            $display("FAIL zero_latency got=%0d want=15", lat);
        end
        checks++;
        if (bcnt !== 15) begin
            failures++;
            $display("FAIL zero_busy_cycles got=%0d want=15", bcnt);
        end
        e = pop_exp();
        checks++;
        if (exp_t'({bcd, ovf, blank}) !== e) begin
            failures++;
            $display("FAIL zero_result got=%h want=%h",
                     {bcd, ovf, blank}, e);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_done_pulse got=%b want=0", done);
        end
    endtask

    task automatic test_1234();
        int lat;
        int bcnt;
        exp_t e;
        launch(1234);
        wait_done(30, lat, bcnt);
        checks++;
        if (lat !== 15) begin
            failures++;
            $display("FAIL v1234_latency got=%0d want=15", lat);
        end
        e = pop_exp();
        checks++;
        if (exp_t'({bcd, ovf, blank}) !== e) begin
            failures++;
            $display("FAIL v1234_result got=%h want=%h",
                     {bcd, ovf, blank}, e);
        end
        for (int i = 0; i < 6; i++) begin
            bin = 14'(i * 2711);
            tick();
        end
        checks++;
        if (exp_t'({bcd, ovf, blank}) !== e) begin
            failures++;
            $display("FAIL v1234_hold got=%h want=%h",
                     {bcd, ovf, blank}, e);
        end
    endtask

    task automatic test_overflow();
        int lat;
        int bcnt;
        int vals[2] = '{10000, 16383};
        exp_t e;
        foreach (vals[i]) begin
            launch(vals[i]);
            wait_done(30, lat, bcnt);
            checks++;
            if (lat !== 15) begin
                failures++;
                $display("FAIL ovf_latency v=%0d got=%0d want=15",
                         vals[i], lat);
            end
            e = pop_exp();
            checks++;
            if (exp_t'({bcd, ovf, blank}) !== e) begin
                failures++;
                $display("FAIL ovf_result v=%0d got=%h want=%h",
                         vals[i], {bcd, ovf, blank}, e);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int nd = 0;
        int lat;
        int bcnt;
        exp_t e;
        launch(42);
        for (int n = 1; n <= 40; n++) begin
            tick();
            start = 1'b0;
            if (done) begin
                nd++;
                e = pop_exp();
                checks++;
                if (exp_t'({bcd, ovf, blank}) !== e) begin
                    failures++;
                    $display("FAIL busy_result got=%h want=%h",
                             {bcd, ovf, blank}, e);
                end
            end
            if (n == 5 || n == 15) begin
                bin   = 14'd77;
                start = 1'b1;
            end
        end
        checks++;
        if (nd !== 1) begin
            failures++;
            $display("FAIL busy_done_count got=%0d want=1", nd);
        end
        launch(77);
        wait_done(30, lat, bcnt);
        checks++;
        if (lat !== 15) begin
            failures++;
            $display("FAIL idle77_latency got=%0d want=15", lat);
        end
        e = pop_exp();
        checks++;
        if (exp_t'({bcd, ovf, blank}) !== e) begin
            failures++;
            $display("FAIL idle77_result got=%h want=%h",
                     {bcd, ovf, blank}, e);
        end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        int lat;
        int bcnt;
        exp_t e;
        bin   = 14'd5678;
        start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            start = 1'b0;
        end
        resetB = 1'b0;
        q.delete();
        #1;
        checks++;
        if ({bcd, busy, done, ovf, blank} !== 23'b0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=0",
                     {bcd, busy, done, ovf, blank});
        end
        tick();
        resetB = 1'b1;
        for (int n = 0; n < 25; n++) begin
            tick();
            if (done)
                nd++;
        end
        checks++;
        if (nd !== 0) begin
            failures++;
            $display("FAIL midreset_no_done got=%0d want=0", nd);
        end
        launch(9999);
        wait_done(30, lat, bcnt);
        checks++;
        if (lat !== 15) begin
            failures++;
            $display("FAIL v9999_latency got=%0d want=15", lat);
        end
        e = pop_exp();
        checks++;
        if (exp_t'({bcd, ovf, blank}) !== e) begin
            failures++;
            $display("FAIL v9999_result got=%h want=%h",
                     {bcd, ovf, blank}, e);
        end
    endtask

    task automatic test_back_to_back();
        int t[$];
        int got;
        exp_t e;
        bin   = 14'd321;
        start = 1'b1;
        // start held over edges 0..39: accepted at 0, 16 and 32
        for (int i = 0; i < 3; i++)
            q.push_back(model(321));
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 40)
                start = 1'b0;
            if (done) begin
                t.push_back(n - 1);
                e = pop_exp();
                checks++;
                if (exp_t'({bcd, ovf, blank}) !== e) begin
                    failures++;
                    $display("FAIL b2b_result got=%h want=%h",
                             {bcd, ovf, blank}, e);
                end
            end
        end
        checks++;
        if (t.size() !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=3", t.size());
        end
        for (int i = 0; i < 3; i++) begin
            got = (i < t.size()) ? t[i] : -1;
            checks++;
            if (got !== 15 + 16 * i) begin
                failures++;
                $display("FAIL b2b_done_cycle%0d got=%0d want=%0d",
                         i, got, 15 + 16 * i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_1234();
        test_overflow();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
